// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and helpers.
// Imported by the fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        END   = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

    // Word-aligned and inside the loaded program image.
    function automatic logic pc_in_range(
        input logic [63:0] pc,
        input int unsigned len
    );
        return (pc[1:0] == 2'b00) && ((pc >> 2) < 64'(len));
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for a 1-cycle synchronous ROM.
// Valid/ready delivery to decode with redirect and fault detection.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    PROGRAM_LENGTH = 10,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  halted_o,
    output logic                  fault_o,
    output logic [31:0]           fetch_count_o
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           count_q;
    logic                  stall, fire;
    logic                  redir_ok, req_ok, reset_ok;

    assign redir_ok = pc_in_range(64'(redirect_pc_i), PROGRAM_LENGTH);
    assign req_ok   = pc_in_range(64'(req_pc_q), PROGRAM_LENGTH);
    assign reset_ok = pc_in_range(64'(RESET_PC), PROGRAM_LENGTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_pc_q    <= RESET_PC;
            rsp_pc_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_pc_q    <= req_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_pc_d    = req_pc_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_valid_d = rsp_valid_q;
        unique case (1'b1)
            (state_q == IDLE): begin
                if (start_i) begin
                    if (reset_ok) begin
                        state_d  = RUN;
                        req_pc_d = RESET_PC;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            (state_q == RUN): begin
                if (redirect_i) begin
                    if (!redir_ok) begin
                        state_d = FAULT;
                    end else begin
                        req_pc_d    = redirect_pc_i;
                        rsp_valid_d = 1'b0;
                    end
                end else if (stall) begin
                    state_d = state_q;
                end else if (req_ok) begin
                    rsp_pc_d    = req_pc_q;
                    rsp_valid_d = 1'b1;
                    req_pc_d    = req_pc_q + ADDR_WIDTH'(INSTR_BYTES);
                end else begin
                    // Drain the last response before declaring END.
                    rsp_valid_d = 1'b0;
                    if (!rsp_valid_q) state_d = END;
                end
            end
            (state_q == END): begin
                if (redirect_i) begin
                    if (redir_ok) begin
                        state_d  = RUN;
                        req_pc_d = redirect_pc_i;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            (state_q == FAULT): begin
                state_d = FAULT;
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        instr_valid_o = rsp_valid_q && (state_q == RUN);
        halted_o      = (state_q == END);
        fault_o       = (state_q == FAULT);
        instr_pc_o    = rsp_pc_q;
        instr_o       = rom_data_i;
        stall         = instr_valid_o && !instr_ready_i;
        fire          = instr_valid_o && instr_ready_i;
        // Re-read the held word so the ROM output stays put while stalled.
        rom_addr_o    = stall ? (rsp_pc_q >> 2) : (req_pc_q >> 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (fire && (count_q != '1)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count_o = count_q;

endmodule
